// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: valid/ready word intake, bit-rate divider,
// and a frame FSM emitting start, LSB-first data, optional parity and stop bits.
module serial_frame_tx #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int DIV_MAX = STOP_BITS * CLK_DIV;
    localparam int DIV_W   = $clog2(DIV_MAX + 1);
    localparam int BIT_W   = $clog2(WIDTH);

    localparam logic [DIV_W-1:0] BIT_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] STOP_LAST = DIV_W'(DIV_MAX - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(WIDTH - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_frame_tx: WIDTH must be >= 2");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("serial_frame_tx: CLK_DIV must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("serial_frame_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("serial_frame_tx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt, w_lim;
    logic [BIT_W-1:0] r_bit, w_bit_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic             r_par, w_par_nxt;
    logic             r_tx, r_ready, r_busy, r_done;
    logic             w_done_nxt, w_bit_end;

    // Line level for a given state, so tx can be registered from next-state values.
    function automatic logic tx_level(input state_t s, input logic [WIDTH-1:0] sh,
                                      input logic p);
        case (s)
            S_START:  return 1'b0;
            S_DATA:   return sh[0];
            S_PARITY: return p;
            default:  return 1'b1;
        endcase
    endfunction

    assign w_lim     = (r_state == S_STOP) ? STOP_LAST : BIT_LAST;
    assign w_bit_end = (r_div == w_lim);

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div + DIV_W'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_div_nxt = '0;
                if (in_valid && r_ready) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = in_data;
                    w_par_nxt   = (^in_data) ^ (PARITY == 2);
                    w_bit_nxt   = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_div_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_div_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == DATA_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_div_nxt   = '0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                    w_div_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_div_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= tx_level(w_state_nxt, w_shift_nxt, w_par_nxt);
            r_ready <= (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign in_ready   = r_ready;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: four instances cover no parity, even, odd
// parity and two stop bits, all with WIDTH=8 and CLK_DIV=4.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       sclr;
    logic [7:0] in_data;
    logic [3:0] vld;
    logic [3:0] rdy_w, tx_w, busy_w, done_w;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(8), .CLK_DIV(4), .PARITY(0), .STOP_BITS(1)) u_none (
        .clk(clk), .sclr(sclr), .in_data(in_data), .in_valid(vld[0]),
        .in_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));
    serial_frame_tx #(.WIDTH(8), .CLK_DIV(4), .PARITY(1), .STOP_BITS(1)) u_even (
        .clk(clk), .sclr(sclr), .in_data(in_data), .in_valid(vld[1]),
        .in_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));
    serial_frame_tx #(.WIDTH(8), .CLK_DIV(4), .PARITY(2), .STOP_BITS(1)) u_odd (
        .clk(clk), .sclr(sclr), .in_data(in_data), .in_valid(vld[2]),
        .in_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));
    serial_frame_tx #(.WIDTH(8), .CLK_DIV(4), .PARITY(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .sclr(sclr), .in_data(in_data), .in_valid(vld[3]),
        .in_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(done_w[3]));

    // exp bit i is the line level during serial bit period i; nb periods of 4 clk each.
    typedef struct {
        int          dut;
        logic [7:0]  data;
        int          nb;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Entered at the negedge just after the accept edge; leaves at the done-cycle negedge.
    task automatic check_frame(input int d, input logic [11:0] exp, input int nb,
                               input string tag);
        int f;
        f = nb * 4;
        for (int n = 0; n < f; n++) begin
            chk($sformatf("%s tx n=%0d", tag, n), tx_w[d], exp[n / 4]);
            chk($sformatf("%s busy n=%0d", tag, n), busy_w[d], 1'b1);
            chk($sformatf("%s ready n=%0d", tag, n), rdy_w[d], 1'b0);
            chk($sformatf("%s done n=%0d", tag, n), done_w[d], 1'b0);
            @(negedge clk);
        end
        chk($sformatf("%s end tx", tag), tx_w[d], 1'b1);
        chk($sformatf("%s end done", tag), done_w[d], 1'b1);
        chk($sformatf("%s end ready", tag), rdy_w[d], 1'b1);
        chk($sformatf("%s end busy", tag), busy_w[d], 1'b0);
    endtask

    task automatic send(input int d, input logic [7:0] data);
        in_data = data;
        vld[d]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[d]  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{dut: 0, data: 8'hA5, nb: 10, exp: 12'h34A};
        vecs[1] = '{dut: 1, data: 8'h07, nb: 11, exp: 12'h60E};
        vecs[2] = '{dut: 1, data: 8'h03, nb: 11, exp: 12'h406};
        vecs[3] = '{dut: 2, data: 8'h00, nb: 11, exp: 12'h600};
        vecs[4] = '{dut: 3, data: 8'hFF, nb: 11, exp: 12'h7FE};

        // Reset with in_valid high on every instance: nothing may be accepted.
        sclr    = 1'b1;
        vld     = 4'hF;
        in_data = 8'h33;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset tx d%0d", d), tx_w[d], 1'b1);
            chk($sformatf("reset ready d%0d", d), rdy_w[d], 1'b1);
            chk($sformatf("reset busy d%0d", d), busy_w[d], 1'b0);
            chk($sformatf("reset done d%0d", d), done_w[d], 1'b0);
        end
        vld  = 4'h0;
        sclr = 1'b0;
        @(negedge clk);

        // Table-driven single frames.
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].dut, vecs[i].data);
            check_frame(vecs[i].dut, vecs[i].exp, vecs[i].nb, $sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d done one cycle", i), done_w[vecs[i].dut], 1'b0);
            chk($sformatf("vec%0d stays idle", i), busy_w[vecs[i].dut], 1'b0);
        end

        // Back-to-back: valid held across two words; second accept lands in the done cycle.
        in_data = 8'h11;
        vld[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = 8'h22;
        check_frame(0, 12'h222, 10, "b2b first");
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        in_data = 8'hC3;
        check_frame(0, 12'h244, 10, "b2b second");
        @(negedge clk);
        chk("b2b no third accept", busy_w[0], 1'b0);

        // Inputs wiggled during a frame must be ignored.
        in_data = 8'h3C;
        vld[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[0]  = 1'b0;
        fork
            check_frame(0, 12'h278, 10, "busy ignore");
            begin
                for (int k = 0; k < 38; k++) begin
                    @(posedge clk);
                    #1;
                    vld[0]  = ((k % 2) == 0);
                    in_data = 8'($urandom);
                end
                vld[0] = 1'b0;
            end
        join
        @(negedge clk);
        chk("busy ignore no extra accept", busy_w[0], 1'b0);
        chk("busy ignore done one cycle", done_w[0], 1'b0);

        // Reset during data bit 3 (frame cycles 16..19).
        send(0, 8'hA5);
        repeat (17) @(negedge clk);
        sclr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sclr = 1'b0;
        chk("midreset tx", tx_w[0], 1'b1);
        chk("midreset ready", rdy_w[0], 1'b1);
        chk("midreset busy", busy_w[0], 1'b0);
        chk("midreset done", done_w[0], 1'b0);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                seen = seen | done_w[0] | busy_w[0];
            end
            chk("midreset no late frame", seen, 1'b0);
        end
        send(0, 8'h5A);
        check_frame(0, 12'h2B4, 10, "after reset");
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
